can_stuff_ctrl: RTL and testbench
=================================

# can_stuff_ctrl

Bit-level receive sequencer for the CAN stuffing path. It hard-syncs on the start-of-frame falling edge and times each bit with a CLKS_PER_BIT counter. At every sample point it tracks the run of identical bits, predicts each stuff bit, and strobes the expected stuff value for comparison. It delivers de-stuffed bits to the frame decoder, counts stuff errors, and returns to idle after bus-idle detection. It sits between the raw RX pin and the frame decoder; it replaces free-running per-clock stuff comparison with comparison only at predicted stuff-bit sample points.

## Interface
- CLKS_PER_BIT, 10, system clocks per CAN bit; legal range ≥ 4.
- i_Clock  in  1  system clock; all logic on its rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Data  in  1  raw serial RX line; asynchronous; 1 = recessive.
- i_Stuff_Enable  in  1  from the frame decoder, high while bits SOF through CRC are on the bus; sampled only at sample points.
- i_Err_Clear  in  1  synchronous clear of o_Err_Count.
- o_Bit_Valid  out  1  one-cycle strobe; o_Bit holds a de-stuffed data bit.
- o_Bit  out  1  de-stuffed bit value; held between strobes.
- o_Stuff_Check  out  1  one-cycle strobe at each predicted stuff-bit sample.
- o_temp_stuff  out  1  expected stuff value, the complement of the run value; valid while o_Stuff_Check is high.
- o_Stuff_Error  out  1  one-cycle strobe on a stuff violation.
- o_Err_Count  out  8  stuff errors since reset or clear; saturates at 255.
- o_Busy  out  1  high in RUN and ERR.

## Operation
- Input conditioning
  - i_Data passes through a 2-flop synchronizer (s1, s2), giving the synchronized line s2.
  - s2 is also registered into a previous-value flop, s2_q.
- States: IDLE, RUN, ERR.
- IDLE
  - Bit counter is held at 0 and run_len at 0.
  - A falling edge (s2_q=1, s2=0) moves the block to RUN with bit counter = 0 and recessive counter = 0.
- RUN and ERR
  - The bit counter counts 0..CLKS_PER_BIT-1 and wraps.
  - The sample point is the cycle where the counter equals CLKS_PER_BIT/2 (integer divide); b = s2 in that cycle.
  - There is no resynchronization other than the hard sync from IDLE.
- Sample-point rules in RUN, evaluated in this order:
  - i_Stuff_Enable=0: deliver b; run_len = 0.
  - i_Stuff_Enable=1 and run_len=5: stuff bit.
    - Assert o_Stuff_Check with o_temp_stuff = ~last. The bit is not delivered.
    - If b == last: pulse o_Stuff_Error, increment o_Err_Count, go to ERR.
    - Otherwise: run_len = 1, last = b.
  - i_Stuff_Enable=1, run_len<5: deliver b.
    - If run_len>0 and b == last: run_len increments.
    - Otherwise: run_len = 1, last = b.
- Recessive counter
  - Increments at every sample with b=1 and clears on b=0, in RUN and ERR alike.
  - Counts stuff bits too.
  - Reaching 11 moves the block to IDLE; that sample is still processed and delivered in RUN.
- ERR
  - No delivery and no checks.
  - Bit timing continues, and the block waits for 11 consecutive recessive samples before entering IDLE.
- o_Err_Count
  - Saturates at 255.
  - i_Err_Clear sets it to 0. If a clear and an error happen in the same cycle, the count becomes 1.
  - Reset has priority over everything.

## Timing
- Reset values:
  - s1, s2, s2_q = 1.
  - State = IDLE; o_Bit_Valid, o_Bit, o_Stuff_Check, o_temp_stuff, o_Stuff_Error, o_Err_Count and o_Busy = 0.
  - run_len, bit counter and recessive counter = 0.
- Edge-to-RUN latency: 2 cycles of synchronizer delay, then RUN is entered on the cycle after the edge is detected.
- All outputs are registered. Each strobe is high for exactly the one cycle after the sample-point cycle.
- o_Busy rises the cycle after the edge is detected and falls the cycle after the 11th recessive sample.
- Reset asserted mid-frame:
  - Aborts the frame; all outputs read reset values on the next cycle.
  - No partial strobe is emitted.

## Test plan
- Stuff-bit skip: CLKS_PER_BIT=10, enable=1; bus bits 0,0,0,0,0,1,0,1… -> six o_Bit_Valid (0,0,0,0,0,0), one o_Stuff_Check with o_temp_stuff=1 at the 6th bit, o_Stuff_Error never asserted.
- Stuff violation: six consecutive 0 bits with enable=1 -> o_Stuff_Error at the 6th sample, o_Err_Count=1, no o_Bit_Valid after the fifth bit; 11 recessive bits -> o_Busy drops, state IDLE.
- Stuffing disabled: enable=0 after SOF, ten identical bits -> ten o_Bit_Valid, zero o_Stuff_Check.
- Bus idle: frame ends with 11 recessive bits -> o_Busy low one cycle after the 11th sample; the next falling edge restarts RUN with run_len=0.
- Counter limits:
  - 256 forced violations -> o_Err_Count stays at 255.
  - i_Err_Clear in the same cycle as an error -> o_Err_Count=1.
- Reset mid-frame: assert i_Reset at bit 3 -> all outputs 0 next cycle, o_Err_Count=0, and the next SOF is decoded correctly.

Source files
------------

// File: rtl/can_stuff_ctrl.sv
// -----------------------------------------------------------------------------
// can_stuff_ctrl
//
// Bit-level receive sequencer for the CAN bit-stuffing path.
//
// The block hard-syncs to the start-of-frame falling edge and times each bit
// with a free-running counter of CLKS_PER_BIT system clocks. At the
// mid-bit sample point it:
//   - tracks the run of identical bits,
//   - predicts where a stuff bit must appear,
//   - checks that bit against the expected (complemented) value, and
//   - hands the remaining bits, with stuff bits removed, to the frame decoder.
//
// Eleven consecutive recessive samples are treated as bus idle and return
// the block to IDLE. A stuff violation parks the block in ERR until that
// happens.
//
// Parameters
//   CLKS_PER_BIT   system clocks per CAN bit (>= 4)
//
// Ports
//   i_Clock         system clock, rising edge
//   i_Reset         synchronous, active-high reset
//   i_Data          raw asynchronous RX line (1 = recessive)
//   i_Stuff_Enable  stuffing region qualifier from the frame decoder
//                   (SOF..CRC); looked at only on sample points
//   i_Err_Clear     synchronous clear of o_Err_Count
//   o_Bit_Valid     one-cycle strobe, o_Bit carries a de-stuffed bit
//   o_Bit           de-stuffed bit value, held between strobes
//   o_Stuff_Check   one-cycle strobe on every predicted stuff-bit sample
//   o_temp_stuff    expected stuff value (complement of the run value)
//   o_Stuff_Error   one-cycle strobe on a stuff violation
//   o_Err_Count     saturating count of stuff errors
//   o_Busy          high while in RUN or ERR
// -----------------------------------------------------------------------------
module can_stuff_ctrl #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Data,
  input  logic       i_Stuff_Enable,
  input  logic       i_Err_Clear,
  output logic       o_Bit_Valid,
  output logic       o_Bit,
  output logic       o_Stuff_Check,
  output logic       o_temp_stuff,
  output logic       o_Stuff_Error,
  output logic [7:0] o_Err_Count,
  output logic       o_Busy
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  SAMPLE_PT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);

  // Five equal bits in a row force a stuff bit; eleven recessive bits in a
  // row mean the bus is idle.
  localparam logic [2:0]        STUFF_RUN = 3'd5;
  localparam logic [3:0]        IDLE_RUN  = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  // Error counter next value: a clear and an error in the same cycle leave
  // exactly one error recorded; otherwise count up and stick at 255.
  function automatic logic [7:0] err_count_next(
    input logic [7:0] cnt,
    input logic       err,
    input logic       clr
  );
    logic [7:0] res;
    res = cnt;
    if (err && clr) begin
      res = 8'd1;
    end else if (err) begin
      res = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    end else if (clr) begin
      res = 8'd0;
    end
    return res;
  endfunction

  // Recessive run length after one more sample of value b.
  function automatic logic [3:0] rec_count_next(
    input logic [3:0] cnt,
    input logic       b
  );
    logic [3:0] res;
    if (!b) begin
      res = 4'd0;
    end else if (cnt == 4'hF) begin
      res = cnt;
    end else begin
      res = cnt + 4'd1;
    end
    return res;
  endfunction

  // Same-bit run length after a delivered data bit b.
  function automatic logic [2:0] run_len_next(
    input logic [2:0] len,
    input logic       last,
    input logic       b
  );
    logic [2:0] res;
    if ((len != 3'd0) && (b == last)) begin
      res = len + 3'd1;
    end else begin
      res = 3'd1;
    end
    return res;
  endfunction

  // Synchronizer and edge-detect history; idle value is recessive.
  logic             s1;
  logic             s2;
  logic             s2_q;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       rec_cnt;
  logic [2:0]       run_len;
  logic             last_bit;

  // Per-cycle decisions, all derived from the current sample.
  logic             fall_edge;
  logic             sample_vld_p0;
  logic             stuff_slot;
  logic             stuff_err;
  logic             bus_idle;

  always_comb begin
    fall_edge     = 1'b0;
    sample_vld_p0 = 1'b0;
    stuff_slot    = 1'b0;
    stuff_err     = 1'b0;
    bus_idle      = 1'b0;

    fall_edge     = s2_q & ~s2;
    sample_vld_p0 = (state != IDLE) && (bit_cnt == SAMPLE_PT);
    stuff_slot    = sample_vld_p0 && (state == RUN) && i_Stuff_Enable &&
                    (run_len == STUFF_RUN);
    stuff_err     = stuff_slot && (s2 == last_bit);
    bus_idle      = sample_vld_p0 && (rec_count_next(rec_cnt, s2) == IDLE_RUN);
  end

  // ---- input conditioning: 2-flop synchronizer plus previous-value flop ----
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1   <= i_Data;
      s2   <= s1;
      s2_q <= s2;
    end
  end

  // ---- bit timing: free-running once hard-synced, no re-sync in a frame ----
  always_ff @(posedge i_Clock) begin
    if (i_Reset || (state == IDLE)) begin
      bit_cnt <= '0;
    end else if (bit_cnt == LAST_CNT) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // ---- recessive run tracking for bus-idle detection (stuff bits count) ----
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rec_cnt <= 4'd0;
    end else if ((state == IDLE) && fall_edge) begin
      rec_cnt <= 4'd0;
    end else if (sample_vld_p0) begin
      rec_cnt <= rec_count_next(rec_cnt, s2);
    end
  end

  // ---- error accounting ----
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Err_Count <= 8'd0;
    end else begin
      o_Err_Count <= err_count_next(o_Err_Count, stuff_err, i_Err_Clear);
    end
  end

  // ---- sequencer: state, run tracking and registered strobes ----
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state         <= IDLE;
      run_len       <= 3'd0;
      last_bit      <= 1'b0;
      o_Bit_Valid   <= 1'b0;
      o_Bit         <= 1'b0;
      o_Stuff_Check <= 1'b0;
      o_temp_stuff  <= 1'b0;
      o_Stuff_Error <= 1'b0;
      o_Busy        <= 1'b0;
    end else begin
      // Strobes default low so each lasts exactly one cycle.
      o_Bit_Valid   <= 1'b0;
      o_Stuff_Check <= 1'b0;
      o_Stuff_Error <= 1'b0;

      case (state)
        IDLE: begin
          run_len <= 3'd0;
          if (fall_edge) begin
            state  <= RUN;
            o_Busy <= 1'b1;
          end
        end

        RUN: begin
          if (sample_vld_p0) begin
            if (!i_Stuff_Enable) begin
              // Outside the stuffed region: pass through, forget the run.
              o_Bit_Valid <= 1'b1;
              o_Bit       <= s2;
              run_len     <= 3'd0;
            end else if (run_len == STUFF_RUN) begin
              // Predicted stuff bit: compare, never deliver.
              o_Stuff_Check <= 1'b1;
              o_temp_stuff  <= ~last_bit;
              if (s2 == last_bit) begin
                o_Stuff_Error <= 1'b1;
                state         <= ERR;
              end else begin
                run_len  <= 3'd1;
                last_bit <= s2;
              end
            end else begin
              o_Bit_Valid <= 1'b1;
              o_Bit       <= s2;
              run_len     <= run_len_next(run_len, last_bit, s2);
              last_bit    <= s2;
            end

            // Bus idle wins over everything else decided on this sample.
            if (bus_idle) begin
              state  <= IDLE;
              o_Busy <= 1'b0;
            end
          end
        end

        ERR: begin
          if (bus_idle) begin
            state  <= IDLE;
            o_Busy <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_stuff_ctrl.sv
module tb_can_stuff_ctrl;

  localparam int CPB = 10;

  logic       i_Clock = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Data = 1'b1;
  logic       i_Stuff_Enable = 1'b0;
  logic       i_Err_Clear = 1'b0;
  logic       o_Bit_Valid;
  logic       o_Bit;
  logic       o_Stuff_Check;
  logic       o_temp_stuff;
  logic       o_Stuff_Error;
  logic [7:0] o_Err_Count;
  logic       o_Busy;

  int checks   = 0;
  int failures = 0;

  // Captured strobes since the last clear_mon.
  logic vq[$];
  logic sq[$];
  int   err_n = 0;

  can_stuff_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (i_Clock),
    .i_Reset        (i_Reset),
    .i_Data         (i_Data),
    .i_Stuff_Enable (i_Stuff_Enable),
    .i_Err_Clear    (i_Err_Clear),
    .o_Bit_Valid    (o_Bit_Valid),
    .o_Bit          (o_Bit),
    .o_Stuff_Check  (o_Stuff_Check),
    .o_temp_stuff   (o_temp_stuff),
    .o_Stuff_Error  (o_Stuff_Error),
    .o_Err_Count    (o_Err_Count),
    .o_Busy         (o_Busy)
  );

  always #5 i_Clock = ~i_Clock;

  always @(negedge i_Clock) begin
    if (o_Bit_Valid)   vq.push_back(o_Bit);
    if (o_Stuff_Check) sq.push_back(o_temp_stuff);
    if (o_Stuff_Error) err_n = err_n + 1;
  end

  task automatic clear_mon();
    vq.delete();
    sq.delete();
    err_n = 0;
  endtask

  // One bus bit: inputs change 1 time unit after a rising edge and are held
  // for CPB clocks; returns 1 time unit after the last edge of the bit.
  task automatic send_bit(input logic b, input logic en);
    i_Data = b;
    i_Stuff_Enable = en;
    repeat (CPB) @(posedge i_Clock);
    #1;
  endtask

  task automatic idle_bus();
    repeat (12) send_bit(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    repeat (3) @(posedge i_Clock);
    #1;
    checks++;
    if ({o_Bit_Valid, o_Bit, o_Stuff_Check, o_temp_stuff, o_Stuff_Error, o_Busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000000",
               {o_Bit_Valid, o_Bit, o_Stuff_Check, o_temp_stuff, o_Stuff_Error, o_Busy});
    end
    checks++;
    if (o_Err_Count !== 8'd0) begin
      failures++;
      $display("FAIL reset_err_count got=%0d exp=0", o_Err_Count);
    end
    i_Reset = 1'b0;
    repeat (2) @(posedge i_Clock);
    #1;
    checks++;
    if (o_Busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy got=%b exp=0", o_Busy);
    end
  endtask

  task automatic test_stuff_skip();
    logic [6:0] bits;
    int ones;
    bits = 7'b0000010; // sent MSB first: 0,0,0,0,0,1,0
    clear_mon();
    for (int i = 6; i >= 0; i--) send_bit(bits[i], 1'b1);
    ones = 0;
    foreach (vq[i]) ones += int'(vq[i]);
    checks++;
    if (vq.size() != 6 || ones != 0) begin
      failures++;
      $display("FAIL skip_valid got=%0d bits (%0d ones) exp=6 bits (0 ones)", vq.size(), ones);
    end
    checks++;
    if (sq.size() != 1 || sq[0] !== 1'b1) begin
      failures++;
      $display("FAIL skip_check got=%0d checks exp=1 check value 1", sq.size());
    end
    send_bit(1'b1, 1'b1);
    checks++;
    if (vq.size() != 7 || vq[vq.size()-1] !== 1'b1) begin
      failures++;
      $display("FAIL skip_bit8 got=%0d bits exp=7 ending in 1", vq.size());
    end
    idle_bus();
    checks++;
    if (err_n != 0 || o_Busy !== 1'b0) begin
      failures++;
      $display("FAIL skip_no_error got=%0d errors busy=%b exp=0 errors busy=0", err_n, o_Busy);
    end
  endtask

  task automatic test_stuff_violation();
    clear_mon();
    repeat (6) send_bit(1'b0, 1'b1);
    checks++;
    if (err_n != 1 || o_Err_Count !== 8'd1) begin
      failures++;
      $display("FAIL viol_error got=%0d strobes count=%0d exp=1 strobe count=1", err_n, o_Err_Count);
    end
    checks++;
    if (vq.size() != 5 || sq.size() != 1) begin
      failures++;
      $display("FAIL viol_delivery got=%0d bits %0d checks exp=5 bits 1 check", vq.size(), sq.size());
    end
    repeat (10) send_bit(1'b1, 1'b1);
    checks++;
    if (o_Busy !== 1'b1 || vq.size() != 5 || sq.size() != 1) begin
      failures++;
      $display("FAIL viol_err_state got busy=%b bits=%0d checks=%0d exp busy=1 bits=5 checks=1",
               o_Busy, vq.size(), sq.size());
    end
    send_bit(1'b1, 1'b1);
    checks++;
    if (o_Busy !== 1'b0) begin
      failures++;
      $display("FAIL viol_idle_busy got=%b exp=0", o_Busy);
    end
    send_bit(1'b1, 1'b0);
  endtask

  task automatic test_stuff_disabled();
    int ones;
    clear_mon();
    // SOF bit driven by hand to watch o_Busy rise.
    i_Data = 1'b0;
    i_Stuff_Enable = 1'b0;
    repeat (2) @(posedge i_Clock);
    #1;
    checks++;
    if (o_Busy !== 1'b0) begin
      failures++;
      $display("FAIL sync_busy_early got=%b exp=0", o_Busy);
    end
    @(posedge i_Clock);
    #1;
    checks++;
    if (o_Busy !== 1'b1) begin
      failures++;
      $display("FAIL sync_busy_rise got=%b exp=1", o_Busy);
    end
    repeat (CPB - 3) @(posedge i_Clock);
    #1;
    repeat (9) send_bit(1'b0, 1'b0);
    ones = 0;
    foreach (vq[i]) ones += int'(vq[i]);
    checks++;
    if (vq.size() != 10 || ones != 0 || sq.size() != 0) begin
      failures++;
      $display("FAIL disabled got=%0d bits %0d ones %0d checks exp=10 bits 0 ones 0 checks",
               vq.size(), ones, sq.size());
    end
    idle_bus();
  endtask

  task automatic test_bus_idle();
    clear_mon();
    send_bit(1'b0, 1'b1);
    repeat (6) send_bit(1'b1, 1'b0);
    repeat (4) send_bit(1'b1, 1'b1);
    checks++;
    if (o_Busy !== 1'b1) begin
      failures++;
      $display("FAIL idle_busy_10 got=%b exp=1", o_Busy);
    end
    send_bit(1'b1, 1'b1);
    checks++;
    if (o_Busy !== 1'b0 || vq.size() != 12) begin
      failures++;
      $display("FAIL idle_busy_11 got busy=%b bits=%0d exp busy=0 bits=12", o_Busy, vq.size());
    end
    send_bit(1'b1, 1'b0);
    // Run length must restart from zero: SOF is a data bit, not a stuff bit.
    clear_mon();
    repeat (5) send_bit(1'b0, 1'b1);
    checks++;
    if (vq.size() != 5 || sq.size() != 0) begin
      failures++;
      $display("FAIL restart_run got=%0d bits %0d checks exp=5 bits 0 checks", vq.size(), sq.size());
    end
    send_bit(1'b1, 1'b1);
    checks++;
    if (sq.size() != 1 || sq[0] !== 1'b1 || vq.size() != 5) begin
      failures++;
      $display("FAIL restart_stuff got=%0d checks %0d bits exp=1 check 5 bits", sq.size(), vq.size());
    end
    idle_bus();
  endtask

  task automatic violate_frame();
    repeat (6) send_bit(1'b0, 1'b1);
    repeat (11) send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
  endtask

  task automatic test_counter_limits();
    i_Err_Clear = 1'b1;
    @(posedge i_Clock);
    #1;
    i_Err_Clear = 1'b0;
    checks++;
    if (o_Err_Count !== 8'd0) begin
      failures++;
      $display("FAIL clear got=%0d exp=0", o_Err_Count);
    end
    repeat (255) violate_frame();
    checks++;
    if (o_Err_Count !== 8'd255) begin
      failures++;
      $display("FAIL count_255 got=%0d exp=255", o_Err_Count);
    end
    violate_frame();
    checks++;
    if (o_Err_Count !== 8'd255) begin
      failures++;
      $display("FAIL count_sat got=%0d exp=255", o_Err_Count);
    end
    // Violation with a clear landing exactly on the error cycle.
    repeat (5) send_bit(1'b0, 1'b1);
    i_Data = 1'b0;
    repeat (8) @(posedge i_Clock);
    #1;
    i_Err_Clear = 1'b1;
    @(posedge i_Clock);
    #1;
    i_Err_Clear = 1'b0;
    @(posedge i_Clock);
    #1;
    checks++;
    if (o_Err_Count !== 8'd1) begin
      failures++;
      $display("FAIL clear_and_error got=%0d exp=1", o_Err_Count);
    end
    repeat (11) send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] got;
    clear_mon();
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    // Bit 3: reset lands on the edge that would register its strobe.
    i_Data = 1'b0;
    repeat (8) @(posedge i_Clock);
    #1;
    i_Reset = 1'b1;
    i_Data = 1'b1;
    @(posedge i_Clock);
    #1;
    checks++;
    if ({o_Bit_Valid, o_Bit, o_Stuff_Check, o_temp_stuff, o_Stuff_Error, o_Busy} !== 6'b0
        || o_Err_Count !== 8'd0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b count=%0d exp=000000 count=0",
               {o_Bit_Valid, o_Bit, o_Stuff_Check, o_temp_stuff, o_Stuff_Error, o_Busy}, o_Err_Count);
    end
    i_Reset = 1'b0;
    repeat (3) send_bit(1'b1, 1'b0);
    checks++;
    if (vq.size() != 2) begin
      failures++;
      $display("FAIL midreset_partial got=%0d bits exp=2", vq.size());
    end
    clear_mon();
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    idle_bus();
    got = 4'hF;
    if (vq.size() >= 4) got = {vq[0], vq[1], vq[2], vq[3]};
    checks++;
    if (got !== 4'b0110 || err_n != 0 || o_Err_Count !== 8'd0) begin
      failures++;
      $display("FAIL midreset_next_sof got=%b errors=%0d exp=0110 errors=0", got, err_n);
    end
  endtask

  initial begin
    test_reset();
    test_stuff_skip();
    test_stuff_violation();
    test_stuff_disabled();
    test_bus_idle();
    test_counter_limits();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
